dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Sequences and shares the single-ported data memory (DM) between two requesters.
  - Master 0: CPU load/store port.
  - Master 1: debug/loader port.
- Round-robin arbitration.
- Adds byte-enable sub-word stores via an internal read-modify-write sequence, because DM only supports full-word writes.
- Sits between the MEM stage / debug unit and DM; drives DM's add/data/write/read/select/wpc inputs.

Parameters:
- AW, 32, address width (byte address)
- DW, 32, data width; fixed at 32, giving 4 byte lanes

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 request; level, held until m0_ack
- m0_we  in  1  1 = store, 0 = load
- m0_be  in  4  byte enables for stores; ignored for loads
- m0_addr  in  AW  byte address; bits [1:0] ignored
- m0_wdata  in  DW  store data, already lane-aligned
- m0_pc  in  32  PC of the store, forwarded for trace
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DW  load data, valid while m0_ack=1
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0; no pc input (trace pc = 0)
- mem_addr  out  AW  to DM add, {latched addr[AW-1:2], 2'b00}
- mem_wdata  out  DW  to DM data
- mem_write  out  1  to DM write
- mem_read  out  1  to DM read
- mem_select  out  1  to DM select; tied 1
- mem_wpc  out  32  to DM wpc
- mem_rdata  in  DW  from DM out; combinational read
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (synchronous):
  - state=IDLE, rr_ptr=0.
  - All acks and rdata = 0; mem_write=mem_read=0.
  - Reset mid-transaction aborts it: no write is issued in the reset cycle, and no ack is ever given for the aborted request.
- States: IDLE, ACCESS, RMW_WR, RESP.
- IDLE:
  - If either req=1, pick the winner, latch its we/be/addr/wdata/pc into internal registers plus gnt_id, then go to ACCESS.
  - Both requesting: winner = rr_ptr. One requesting: that one wins.
  - Memory outputs are inactive.
- ACCESS:
  - mem_addr comes from the latched address; mem_read=1.
  - Load: capture mem_rdata into rdata_q, go to RESP.
  - Store with be=4'hF: mem_write=1 with the latched wdata this cycle, go to RESP.
  - Store with partial be (nonzero): compute merged word. Lane i takes wdata when be[i]=1, else mem_rdata. Register it, go to RMW_WR. No write is issued this cycle.
  - Store with be=4'h0: no write, go to RESP (acked nop).
- RMW_WR: mem_write=1, mem_wdata = merged word, go to RESP.
- RESP:
  - ack[gnt_id]=1 for exactly one cycle; that master's rdata = rdata_q (zero for stores). The other master's ack stays 0.
  - rr_ptr <= ~gnt_id.
  - Go to IDLE.
- Latency from req sampled in IDLE at cycle T:
  - Load, full store or nop: ack at T+2.
  - Partial store: ack at T+3.
  - Minimum spacing between grants: 3 cycles.
- Handshake:
  - The master holds req and its fields stable until it sees ack, then drops req in the following cycle.
  - Fields are latched in IDLE, so later changes are harmless.
  - A req still high in the cycle after ack is treated as a new request.
- mem_wpc = latched pc for master 0, 32'h0 for master 1; meaningful only while mem_write=1.
- Never more than one mem_write per transaction.
- Address bits above the DM range pass through untouched; DM truncates them.

Decomposition:
- Package dm_arb_pkg:
  - state enum {IDLE, ACCESS, RMW_WR, RESP}
  - BE_FULL = 4'hF
  - NUM_MASTERS = 2
- Sub-module byte_merge: combinational, (old, new, be) -> merged; instantiated once in ACCESS.

Test Plan:
- m0 full store addr=0x10, wdata=0xDEADBEEF, be=F, then m0 load 0x10 -> one write at ACCESS with mem_addr=0x10; store ack at T+2; load returns m0_rdata=0xDEADBEEF at T+2.
- Memory word 0x20 = 0x11223344; m1 store be=4'b0010, wdata=0x0000AB00 -> no write in ACCESS, write of 0x1122AB44 in RMW_WR; m1_ack at T+3.
- m0 and m1 request together, repeatedly after reset -> grant order m0, m1, m0, m1; each ack is a single cycle; the non-winner's ack stays 0 while it waits.
- Only m1 requests, then both request -> m1 served; rr_ptr=0, so m0 wins next.
- Store with be=0 -> no mem_write at all; ack at T+2.
- Reset asserted during RMW_WR of a partial store -> no mem_write in that cycle, no ack; state=IDLE and busy=0 next cycle; a following m0 load is granted first.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RMW_WR = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam logic [3:0] BE_FULL     = 4'hF;
   localparam int         NUM_MASTERS = 2;

endpackage

// File: rtl/dm_arbiter_byte_merge.sv
// Byte-lane merge for sub-word stores: lanes with be set take the new data,
// all other lanes keep the word currently held in memory.
module byte_merge #(
   parameter int DW = 32
) (
   input  logic [DW-1:0]   old_word,
   input  logic [DW-1:0]   new_word,
   input  logic [DW/8-1:0] be,
   output logic [DW-1:0]   merged
);

   // Per-lane select between memory contents and store data.
   always_comb begin
      merged = old_word;
      for (int i = 0; i < DW/8; i++) begin
         if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter in front of the single-ported data memory.
// Partial stores are turned into a read (ACCESS) followed by a full-word
// write of the merged data (RMW_WR), since DM only writes whole words.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            reset,
   // master 0: CPU load/store port
   input  logic            m0_req,
   input  logic            m0_we,
   input  logic [DW/8-1:0] m0_be,
   input  logic [AW-1:0]   m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   input  logic [31:0]     m0_pc,
   output logic            m0_ack,
   output logic [DW-1:0]   m0_rdata,
   // master 1: debug/loader port
   input  logic            m1_req,
   input  logic            m1_we,
   input  logic [DW/8-1:0] m1_be,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   output logic            m1_ack,
   output logic [DW-1:0]   m1_rdata,
   // data memory side
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic            mem_write,
   output logic            mem_read,
   output logic            mem_select,
   output logic [31:0]     mem_wpc,
   input  logic [DW-1:0]   mem_rdata,
   output logic            busy
);

   state_e                 state_q, state_d;
   logic                   rr_q, rr_d;
   logic                   gnt_q, gnt_d;
   logic                   we_q, we_d;
   logic [DW/8-1:0]        be_q, be_d;
   logic [AW-3:0]          waddr_q, waddr_d;
   logic [DW-1:0]          wdata_q, wdata_d;
   logic [31:0]            pc_q, pc_d;
   logic [DW-1:0]          merged_q, merged_d;
   logic [DW-1:0]          rdata_q, rdata_d;
   logic [NUM_MASTERS-1:0] ack_q, ack_d;
   logic [DW-1:0]          merge_w;

   byte_merge #(.DW(DW)) u_merge (
      .old_word (mem_rdata),
      .new_word (wdata_q),
      .be       (be_q),
      .merged   (merge_w)
   );

   // Next-state, request latching and response generation.
   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      gnt_d    = gnt_q;
      we_d     = we_q;
      be_d     = be_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      pc_d     = pc_q;
      merged_d = merged_q;
      rdata_d  = rdata_q;
      ack_d    = '0;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               // tie goes to rr_ptr, otherwise the sole requester wins
               gnt_d   = (m0_req && m1_req) ? rr_q : m1_req;
               we_d    = gnt_d ? m1_we    : m0_we;
               be_d    = gnt_d ? m1_be    : m0_be;
               waddr_d = gnt_d ? m1_addr[AW-1:2] : m0_addr[AW-1:2];
               wdata_d = gnt_d ? m1_wdata : m0_wdata;
               pc_d    = gnt_d ? 32'h0    : m0_pc;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            rdata_d = we_q ? '0 : mem_rdata;
            if (we_q && be_q != BE_FULL && be_q != '0) begin
               merged_d = merge_w;
               state_d  = RMW_WR;
            end else begin
               ack_d[gnt_q] = 1'b1;
               state_d      = RESP;
            end
         end
         RMW_WR: begin
            ack_d[gnt_q] = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            rr_d    = ~gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; synchronous reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_q     <= 1'b0;
         gnt_q    <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         pc_q     <= '0;
         merged_q <= '0;
         rdata_q  <= '0;
         ack_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         gnt_q    <= gnt_d;
         we_q     <= we_d;
         be_q     <= be_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         pc_q     <= pc_d;
         merged_q <= merged_d;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
      end
   end

   // Memory strobes are decoded from state and masked by reset so an
   // aborted read-modify-write never reaches DM.
   always_comb begin
      mem_addr   = {waddr_q, 2'b00};
      mem_read   = !reset && state_q == ACCESS;
      mem_write  = !reset && ((state_q == ACCESS && we_q && be_q == BE_FULL) ||
                              state_q == RMW_WR);
      mem_wdata  = (state_q == RMW_WR) ? merged_q : wdata_q;
      mem_wpc    = gnt_q ? 32'h0 : pc_q;
      mem_select = 1'b1;
      busy       = state_q != IDLE;
      m0_ack     = ack_q[0];
      m1_ack     = ack_q[1];
      m0_rdata   = ack_q[0] ? rdata_q : '0;
      m1_rdata   = ack_q[1] ? rdata_q : '0;
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with a behavioural DM and an ack scoreboard.
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [3:0]  m0_be, m1_be;
   logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_wpc, mem_rdata;
   logic        mem_write, mem_read, mem_select, busy;

   always #5 clk = ~clk;

   dm_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_pc(m0_pc), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_read(mem_read), .mem_select(mem_select), .mem_wpc(mem_wpc),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // behavioural DM: combinational read, full-word write, bench preload port
   logic [31:0] dm [0:255];
   logic        pre_we = 1'b0;
   logic [31:0] pre_addr = '0, pre_data = '0;
   assign mem_rdata = dm[mem_addr[9:2]];
   always @(posedge clk) begin
      if (mem_write)   dm[mem_addr[9:2]] <= mem_wdata;
      else if (pre_we) dm[pre_addr[9:2]] <= pre_data;
   end

   int nchk = 0, npass = 0;
   int wr_cnt = 0;
   logic [31:0] wr_addr, wr_data, wr_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // write monitor
   always @(negedge clk) begin
      if (mem_write) begin
         wr_cnt++;
         wr_addr = mem_addr;
         wr_data = mem_wdata;
         wr_pc   = mem_wpc;
      end
   end

   // scoreboard: expected {master, rdata} per grant, in grant order
   typedef struct { bit id; logic [31:0] rd; } sb_t;
   sb_t sb[$];
   logic prev0 = 1'b0, prev1 = 1'b0;

   always @(negedge clk) begin
      sb_t e;
      if (m0_ack || m1_ack) begin
         chk("ack_exclusive", 32'(m0_ack & m1_ack), 32'h0);
         chk("ack_pulse", 32'((m0_ack & prev0) | (m1_ack & prev1)), 32'h0);
         if (sb.size() == 0) begin
            nchk++;
            $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b expected none", m0_ack, m1_ack);
         end else begin
            e = sb.pop_front();
            chk("ack_id", 32'(m1_ack), 32'(e.id));
            chk("ack_rdata", m1_ack ? m1_rdata : m0_rdata, e.rd);
         end
      end
      prev0 = m0_ack;
      prev1 = m1_ack;
   end

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   task automatic drive(input bit m, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
      if (!m) begin
         m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata; m0_pc = pc; m0_req = 1'b1;
      end else begin
         m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
      end
   endtask

   // one transaction from a single master; lat counts cycles from req sample to ack
   task automatic txn(input bit m, input bit we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] pc, input logic [31:0] exp_rd,
                      output int lat);
      bit got = 0;
      sb.push_back('{m, exp_rd});
      wr_cnt = 0;
      drive(m, we, be, addr, wdata, pc);
      lat = 0;
      while (!got && lat < 10) begin
         @(negedge clk);
         if (m ? m1_ack : m0_ack) got = 1;
         else lat++;
      end
      @(posedge clk); #1;
      if (!m) m0_req = 1'b0; else m1_req = 1'b0;
   endtask

   // both masters load at once; scoreboard enforces the expected grant order
   task automatic both_round(input bit first);
      bit got0 = 0, got1 = 0, a0, a1;
      sb.push_back('{first,  first ? 32'h1122AB44 : 32'hDEADBEEF});
      sb.push_back('{~first, first ? 32'hDEADBEEF : 32'h1122AB44});
      drive(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'h0);
      for (int c = 0; c < 20 && !(got0 && got1); c++) begin
         @(negedge clk);
         a0 = m0_ack; a1 = m1_ack;
         if (a0) got0 = 1;
         if (a1) got1 = 1;
         @(posedge clk); #1;
         if (a0) m0_req = 1'b0;
         if (a1) m1_req = 1'b0;
      end
      chk("both_done", 32'({got0, got1}), 32'h3);
   endtask

   typedef struct {
      bit m; bit we; logic [3:0] be; logic [31:0] addr, wdata;
      bit pre; logic [31:0] init;
      int nwr; logic [31:0] exp_wdata; int lat; logic [31:0] exp_rd, exp_mem;
   } vec_t;

   vec_t vt[8];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lat;
      logic [31:0] pc;
      vt[0] = '{0, 1, 4'hF, 32'h10,       32'hDEADBEEF, 1, 32'h0,        1, 32'hDEADBEEF, 2, 32'h0,        32'hDEADBEEF};
      vt[1] = '{0, 0, 4'h0, 32'h10,       32'h0,        0, 32'h0,        0, 32'h0,        2, 32'hDEADBEEF, 32'hDEADBEEF};
      vt[2] = '{1, 1, 4'h2, 32'h20,       32'h0000AB00, 1, 32'h11223344, 1, 32'h1122AB44, 3, 32'h0,        32'h1122AB44};
      vt[3] = '{0, 1, 4'h0, 32'h30,       32'h99999999, 1, 32'h55555555, 0, 32'h0,        2, 32'h0,        32'h55555555};
      vt[4] = '{0, 1, 4'h9, 32'h44,       32'hAABBCCDD, 1, 32'h01020304, 1, 32'hAA0203DD, 3, 32'h0,        32'hAA0203DD};
      vt[5] = '{1, 0, 4'h0, 32'h23,       32'h0,        0, 32'h0,        0, 32'h0,        2, 32'h1122AB44, 32'h1122AB44};
      vt[6] = '{1, 1, 4'hF, 32'h80000104, 32'hCAFEF00D, 1, 32'h0,        1, 32'hCAFEF00D, 2, 32'h0,        32'hCAFEF00D};
      vt[7] = '{0, 1, 4'h4, 32'h48,       32'h00770000, 1, 32'hFFFFFFFF, 1, 32'hFF77FFFF, 3, 32'h0,        32'hFF77FFFF};

      reset = 1'b1;
      m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0; m0_pc = 0;
      m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_acks",  32'({m0_ack, m1_ack}), 32'h0);
      chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
      chk("rst_mem",   32'({mem_write, mem_read}), 32'h0);
      chk("rst_sel",   32'(mem_select), 32'h1);
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         pc = 32'h4000_0000 + 32'(i * 4);
         if (vt[i].pre) preload(vt[i].addr, vt[i].init);
         txn(vt[i].m, vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, pc, vt[i].exp_rd, lat);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
         chk($sformatf("v%0d_nwr", i), 32'(wr_cnt), 32'(vt[i].nwr));
         if (vt[i].nwr != 0) begin
            chk($sformatf("v%0d_wdata", i), wr_data, vt[i].exp_wdata);
            chk($sformatf("v%0d_waddr", i), wr_addr, vt[i].addr & ~32'h3);
            chk($sformatf("v%0d_wpc", i), wr_pc, vt[i].m ? 32'h0 : pc);
         end
         chk($sformatf("v%0d_dm", i), dm[vt[i].addr[9:2]], vt[i].exp_mem);
      end

      // m0 was served last: a tie now goes to m1
      both_round(1'b1);
      // m1 alone, then a tie goes to m0
      txn(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'h0, 32'h1122AB44, lat);
      chk("m1_alone_lat", 32'(lat), 32'h2);
      both_round(1'b0);

      // leave rr_ptr pointing at m1, then abort a partial store in RMW_WR
      txn(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h0, 32'hDEADBEEF, lat);
      preload(32'h60, 32'h11223344);
      wr_cnt = 0;
      drive(1'b1, 1'b1, 4'h2, 32'h60, 32'h0000AB00, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1; m1_req = 1'b0;
      @(negedge clk);
      chk("abort_no_write", 32'(mem_write), 32'h0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_wr_cnt", 32'(wr_cnt), 32'h0);
      chk("abort_dm", dm[8'h18], 32'h11223344);
      repeat (3) @(posedge clk);
      #1;
      // after reset rr_ptr is 0 again: m0 first, and the order keeps alternating
      both_round(1'b0);
      both_round(1'b0);
      both_round(1'b0);
      repeat (2) @(posedge clk);
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
